// File: rtl/instr_pkg.sv
// Shared definitions for the instruction decoder: bus layout, global command codes
// and decoder state encodings.
package instr_pkg;

    localparam int INSTR_W = 21;

    // Field order mirrors the bus, MSB first: save_core_sel at bit 20 down to global_cmd at 2:0.
    typedef struct packed {
        logic       save_core_sel;
        logic       ram_we;
        logic [7:0] addr;
        logic [1:0] in_sel;
        logic       out_sel;
        logic       out_en;
        logic [3:0] alu_opcode;
        logic [2:0] gcmd;
    } instr_t;

    localparam logic [2:0] GCMD_EXEC     = 3'd0;
    localparam logic [2:0] GCMD_CLEAR    = 3'd1;
    localparam logic [2:0] GCMD_CORE_RST = 3'd2;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_CLEAR     = 2'd1;
    localparam logic [1:0] ST_RST_PULSE = 2'd2;

    // Codes above CORE_RST are undefined and degrade to a strobe-free EXEC.
    function automatic logic is_bad_cmd(input logic [2:0] cmd);
        return (cmd > GCMD_CORE_RST);
    endfunction

endpackage

// File: rtl/ram_clear_sequencer.sv
// Address counter for the RAM clear sweep: one word per cycle from 0 to CLEAR_WORDS-1.
module ram_clear_sequencer
    import instr_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int CLEAR_WORDS = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              last_o,
    output logic [ADDR_W-1:0] addr_o
);

    // One extra bit keeps a full-depth sweep from wrapping before termination.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(CLEAR_WORDS - 1);

    logic [ADDR_W:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            last_s;

    assign last_s = busy_q && (cnt_q == LAST_IDX);

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            cnt_d  = {(ADDR_W + 1){1'b0}};
            busy_d = 1'b1;
        end else if (last_s) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            cnt_d = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
        end else begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= {(ADDR_W + 1){1'b0}};
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign last_o = last_s;
    assign addr_o = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/instruction_decoder.sv
// Registers the 21-bit instruction bus into hash-core strobes and runs CLEAR / core-reset.
// Define DECODER_ERR_EN to add the sticky err_o = {overrun, bad_cmd} port.
module instruction_decoder
    import instr_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int CORE_SEL_W  = 4,
    parameter int CLEAR_WORDS = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INSTR_W-1:0]    instruction_i,
    input  logic                  instr_valid_i,
    input  logic [CORE_SEL_W-1:0] core_match_i,
    output logic [3:0]            alu_opcode_o,
    output logic                  alu_en_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    output logic                  ram_we_o,
    output logic                  ram_clr_o,
    output logic [1:0]            input_select_o,
    output logic                  output_select_o,
    output logic                  output_enable_o,
    output logic                  core_rst_o,
    output logic [CORE_SEL_W-1:0] core_select_o,
    output logic                  busy_o
`ifdef DECODER_ERR_EN
    ,
    output logic [1:0]            err_o
`endif
);

    instr_t                instr_s;
    logic                  accept_s;
    logic                  seq_start_s, seq_busy_s, seq_last_s;
    logic [ADDR_W-1:0]     seq_addr_s;

    logic [1:0]            state_q, state_d;
    logic [3:0]            opc_q, opc_d;
    logic                  alu_en_q, alu_en_d;
    logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
    logic                  ram_we_q, ram_we_d;
    logic [1:0]            in_sel_q, in_sel_d;
    logic                  out_sel_q, out_sel_d;
    logic                  out_en_q, out_en_d;
    logic                  core_rst_q, core_rst_d;
    logic [CORE_SEL_W-1:0] core_sel_q, core_sel_d;
    logic                  busy_q, busy_d;

    assign instr_s  = instr_t'(instruction_i);
    assign accept_s = instr_valid_i && (state_q != ST_CLEAR);

    ram_clear_sequencer #(
        .ADDR_W      (ADDR_W),
        .CLEAR_WORDS (CLEAR_WORDS)
    ) u_clr_seq (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (seq_start_s),
        .busy_o  (seq_busy_s),
        .last_o  (seq_last_s),
        .addr_o  (seq_addr_s)
    );

    always_comb begin
        state_d     = state_q;
        opc_d       = opc_q;
        alu_en_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        in_sel_d    = in_sel_q;
        out_sel_d   = out_sel_q;
        out_en_d    = out_en_q;
        core_rst_d  = 1'b0;
        core_sel_d  = core_sel_q;
        seq_start_s = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                // Park the address register on the final swept word so the port holds it.
                if (seq_last_s) begin
                    state_d    = ST_IDLE;
                    ram_addr_d = seq_addr_s;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_IDLE, ST_RST_PULSE: begin
                state_d = ST_IDLE;
                if (accept_s) begin
                    case (instr_s.gcmd)
                        GCMD_CLEAR: begin
                            state_d     = ST_CLEAR;
                            seq_start_s = 1'b1;
                        end
                        GCMD_CORE_RST: begin
                            state_d    = ST_RST_PULSE;
                            core_rst_d = 1'b1;
                        end
                        default: begin
                            opc_d      = instr_s.alu_opcode;
                            ram_addr_d = ADDR_W'(instr_s.addr);
                            in_sel_d   = instr_s.in_sel;
                            out_sel_d  = instr_s.out_sel;
                            out_en_d   = instr_s.out_en;
                            alu_en_d   = !is_bad_cmd(instr_s.gcmd);
                            ram_we_d   = instr_s.ram_we && !is_bad_cmd(instr_s.gcmd);
                            if (instr_s.save_core_sel) begin
                                core_sel_d = core_match_i;
                            end else begin
                                core_sel_d = core_sel_q;
                            end
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            opc_q      <= 4'd0;
            alu_en_q   <= 1'b0;
            ram_addr_q <= {ADDR_W{1'b0}};
            ram_we_q   <= 1'b0;
            in_sel_q   <= 2'd0;
            out_sel_q  <= 1'b0;
            out_en_q   <= 1'b0;
            core_rst_q <= 1'b0;
            core_sel_q <= {CORE_SEL_W{1'b0}};
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            opc_q      <= opc_d;
            alu_en_q   <= alu_en_d;
            ram_addr_q <= ram_addr_d;
            ram_we_q   <= ram_we_d;
            in_sel_q   <= in_sel_d;
            out_sel_q  <= out_sel_d;
            out_en_q   <= out_en_d;
            core_rst_q <= core_rst_d;
            core_sel_q <= core_sel_d;
            busy_q     <= busy_d;
        end
    end

    assign alu_opcode_o    = opc_q;
    assign alu_en_o        = alu_en_q;
    assign ram_addr_o      = seq_busy_s ? seq_addr_s : ram_addr_q;
    assign ram_we_o        = ram_we_q | seq_busy_s;
    assign ram_clr_o       = seq_busy_s;
    assign input_select_o  = in_sel_q;
    assign output_select_o = out_sel_q;
    assign output_enable_o = out_en_q;
    assign core_rst_o      = core_rst_q;
    assign core_select_o   = core_sel_q;
    assign busy_o          = busy_q;

`ifdef DECODER_ERR_EN
    logic [1:0] err_q;

    // Sticky flags: bit 1 overrun (instruction while busy), bit 0 undefined command.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 2'b00;
        end else begin
            err_q <= err_q | {instr_valid_i && busy_q,
                              accept_s && is_bad_cmd(instr_s.gcmd)};
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed scoreboard bench for instruction_decoder (CLEAR_WORDS = 256).
module tb_instruction_decoder;

    typedef struct packed {
        logic [3:0] opc;
        logic       alu_en;
        logic [7:0] addr;
        logic       we;
        logic       clr;
        logic [1:0] isel;
        logic       osel;
        logic       oen;
        logic       crst;
        logic [3:0] csel;
        logic       busy;
    } obs_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [20:0] instruction_i;
    logic        instr_valid_i;
    logic [3:0]  core_match_i;
    logic [3:0]  alu_opcode_o;
    logic        alu_en_o;
    logic [7:0]  ram_addr_o;
    logic        ram_we_o;
    logic        ram_clr_o;
    logic [1:0]  input_select_o;
    logic        output_select_o;
    logic        output_enable_o;
    logic        core_rst_o;
    logic [3:0]  core_select_o;
    logic        busy_o;
`ifdef DECODER_ERR_EN
    logic [1:0]  err_o;
`endif

    int   total = 0;
    int   bad   = 0;
    obs_t exp_q[$];
    obs_t ex;

    always #5 clk_i = ~clk_i;

    instruction_decoder #(
        .ADDR_W      (8),
        .CORE_SEL_W  (4),
        .CLEAR_WORDS (256)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .instruction_i   (instruction_i),
        .instr_valid_i   (instr_valid_i),
        .core_match_i    (core_match_i),
        .alu_opcode_o    (alu_opcode_o),
        .alu_en_o        (alu_en_o),
        .ram_addr_o      (ram_addr_o),
        .ram_we_o        (ram_we_o),
        .ram_clr_o       (ram_clr_o),
        .input_select_o  (input_select_o),
        .output_select_o (output_select_o),
        .output_enable_o (output_enable_o),
        .core_rst_o      (core_rst_o),
        .core_select_o   (core_select_o),
        .busy_o          (busy_o)
`ifdef DECODER_ERR_EN
        ,
        .err_o           (err_o)
`endif
    );

    function automatic logic [20:0] enc(input logic s, input logic w, input logic [7:0] a,
                                        input logic [1:0] is, input logic os, input logic oe,
                                        input logic [3:0] op, input logic [2:0] c);
        return {s, w, a, is, os, oe, op, c};
    endfunction

    function automatic obs_t observe();
        return {alu_opcode_o, alu_en_o, ram_addr_o, ram_we_o, ram_clr_o, input_select_o,
                output_select_o, output_enable_o, core_rst_o, core_select_o, busy_o};
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare one cycle later.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [20:0] ins, input logic [3:0] m);
        obs_t got;
        obs_t want;
        rst_i         = r;
        instr_valid_i = v;
        instruction_i = ins;
        core_match_i  = m;
        exp_q.push_back(ex);
        @(posedge clk_i);
        #1;
        got  = observe();
        want = exp_q.pop_front();
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, want);
        end
    endtask

`ifdef DECODER_ERR_EN
    task automatic chk_err(input string tag, input logic [1:0] want);
        total++;
        assert (err_o === want) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, err_o, want);
        end
    endtask
`endif

    initial begin
        rst_i         = 1'b1;
        instr_valid_i = 1'b0;
        instruction_i = 21'd0;
        core_match_i  = 4'd0;
        ex            = '0;

        step("reset0", 1'b1, 1'b1, 21'h1FFFFF, 4'hF);
        step("reset1", 1'b1, 1'b0, 21'd0, 4'd0);
`ifdef DECODER_ERR_EN
        chk_err("err_reset", 2'b00);
`endif
        step("valid_low", 1'b0, 1'b0, 21'h1FFFFF, 4'hF);

        ex.opc = 4'd3; ex.alu_en = 1'b1;
        step("exec_opc3", 1'b0, 1'b1, 21'h000018, 4'd0);
        ex.alu_en = 1'b0;
        step("exec_hold", 1'b0, 1'b0, 21'd0, 4'd0);

        ex = '{opc: 4'hA, alu_en: 1'b1, addr: 8'h5A, we: 1'b1, clr: 1'b0, isel: 2'd2,
               osel: 1'b1, oen: 1'b1, crst: 1'b0, csel: 4'd5, busy: 1'b0};
        step("exec_latch", 1'b0, 1'b1, enc(1'b1, 1'b1, 8'h5A, 2'd2, 1'b1, 1'b1, 4'hA, 3'd0), 4'd5);
        ex.alu_en = 1'b0; ex.we = 1'b0;
        step("sel_hold", 1'b0, 1'b0, 21'd0, 4'd9);

        ex.crst = 1'b1;
        step("core_rst", 1'b0, 1'b1, enc(1'b1, 1'b1, 8'hFF, 2'd1, 1'b0, 1'b0, 4'h6, 3'd2), 4'd3);
        ex.crst = 1'b0;
        step("core_rst_end", 1'b0, 1'b0, 21'd0, 4'd0);

        ex.opc = 4'd7; ex.addr = 8'h33; ex.isel = 2'd1; ex.osel = 1'b0; ex.oen = 1'b1; ex.csel = 4'd2;
        step("bad_cmd", 1'b0, 1'b1, enc(1'b1, 1'b1, 8'h33, 2'd1, 1'b0, 1'b1, 4'h7, 3'd6), 4'd2);
`ifdef DECODER_ERR_EN
        chk_err("err_bad_cmd", 2'b01);
`endif

        // Full sweep; an EXEC arrives while address 17 is on the bus and must be dropped.
        ex.busy = 1'b1; ex.we = 1'b1; ex.clr = 1'b1; ex.addr = 8'd0;
        step("clr_start", 1'b0, 1'b1, enc(1'b1, 1'b0, 8'hAB, 2'd3, 1'b1, 1'b0, 4'h1, 3'd1), 4'd8);
        for (int i = 1; i < 256; i++) begin
            ex.addr = 8'(i);
            if (i == 18) begin
                step("clr_overrun", 1'b0, 1'b1, enc(1'b1, 1'b1, 8'h44, 2'd0, 1'b1, 1'b1, 4'hC, 3'd0), 4'hF);
            end else begin
                step("clr_sweep", 1'b0, 1'b0, 21'd0, 4'd0);
            end
        end
        ex.busy = 1'b0; ex.we = 1'b0; ex.clr = 1'b0;
        step("clr_done", 1'b0, 1'b0, 21'd0, 4'd0);
`ifdef DECODER_ERR_EN
        chk_err("err_overrun", 2'b11);
`endif

        ex.busy = 1'b1; ex.we = 1'b1; ex.clr = 1'b1; ex.addr = 8'd0;
        step("clr2_start", 1'b0, 1'b1, enc(1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 4'h0, 3'd1), 4'd0);
        for (int i = 1; i <= 100; i++) begin
            ex.addr = 8'(i);
            step("clr2_sweep", 1'b0, 1'b0, 21'd0, 4'd0);
        end
        ex = '0;
        step("rst_mid_clear", 1'b1, 1'b0, 21'd0, 4'd0);
`ifdef DECODER_ERR_EN
        chk_err("err_cleared", 2'b00);
`endif
        step("post_rst_idle", 1'b0, 1'b0, 21'd0, 4'd0);
        ex.opc = 4'd5; ex.alu_en = 1'b1; ex.addr = 8'h12;
        step("exec_after_rst", 1'b0, 1'b1, enc(1'b0, 1'b0, 8'h12, 2'd0, 1'b0, 1'b0, 4'h5, 3'd0), 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
